dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle ARM core. It is the memory end of the core's load/store interface: the core drives an address, write data and direction, and this block answers with read data after a fixed, parameterised wait. A ready/valid handshake lets the core stall while the access is outstanding. The block holds a word-organised little-endian RAM, supports word and byte (LDRB/STRB) accesses, and reports misaligned or out-of-range accesses as faults.

## Interface

Parameters:
- DEPTH, 64: number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2: wait cycles between accept and access, must be ≥1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (asserted at 0).
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access, 0 = word access.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte stores use bits 7:0.
- rsp_valid  output  1  one-cycle pulse: response present.
- rsp_rdata  output  32  load data; zero-extended for byte loads.
- rsp_fault  output  1  access rejected; valid while rsp_valid=1.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, the block captures we, byte, addr and wdata, computes the fault flag, loads cnt=LATENCY-1 and moves to WAIT.
- Fault: word access with addr[1:0]≠0, or word index addr[31:2] ≥ DEPTH. A byte access faults only on range. There is no aliasing; high address bits are never truncated.
- WAIT: req_ready=0. At each edge, if cnt≠0 then cnt decrements; if cnt=0 the access is performed and the state moves to RESP.
- The access takes effect on the WAIT→RESP edge:
  - Word store with no fault: mem[idx] ← wdata.
  - Byte store with no fault: only lane addr[1:0] is written (lane 0 = bits 7:0); the other lanes are unchanged.
  - Load with no fault: rsp_rdata ← mem[idx] (word load), or the selected byte zero-extended (byte load).
  - Store, or any faulted access: rsp_rdata ← 0.
  - A faulted access never modifies memory.
- RESP: rsp_valid=1 and rsp_fault is set from the captured flag. req_ready=0. The next edge returns to IDLE unconditionally; the core must sample the response in this cycle.
- rsp_rdata holds its value outside RESP. rsp_fault reads 0 outside RESP.
- Request inputs are ignored outside IDLE. Holding req_valid high produces back-to-back accepts, one per LATENCY+2 cycles.
- Reset asserted (0) in any state forces IDLE immediately and discards any pending request. If the reset falls in WAIT, memory is not written. RAM contents are not reset.

## Timing

- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0; state IDLE, cnt=0.
- The accept edge is E0. WAIT occupies the LATENCY cycles after E0. rsp_valid is high during the cycle after edge E0+LATENCY, which is cycle LATENCY+1 counted from E0. IDLE resumes after edge E0+LATENCY+1.
- With LATENCY=2: accept at E0, WAIT for 2 cycles, RESP on cycle 3, next accept possible at edge E0+4.
- All outputs are registered or decoded from state only. There is no combinational path from the req_* inputs to any output.
- A write is visible to a load accepted in the IDLE cycle that immediately follows its RESP.

## Test plan

All scenarios use DEPTH=64 and LATENCY=2.

- Reset: drive reset=0 mid-stream, then release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0 both during and after reset.
- Word store then load: word store 0xDEADBEEF to 0x10, then word load from 0x10 → rsp_valid high in exactly cycle 3 after each accept, rsp_rdata=0xDEADBEEF, rsp_fault=0; the store's response has rsp_rdata=0.
- Byte lanes: from the 0x10 state above, byte store 0x000000A5 to 0x13, then word load from 0x10 → 0xA5ADBEEF. Byte load from 0x12 → 0x000000AD.
- Faults:
  - Word load from 0x22 → rsp_fault=1, rsp_rdata=0.
  - Word store 0x12345678 to 0x100 (index 64) → fault; a subsequent load from 0x0 returns its prior value, showing no aliasing.
  - Byte load from 0x23 → no fault.
- Stall and abort:
  - Hold req_valid=1 continuously → req_ready low in WAIT and RESP, accepts spaced exactly 4 cycles apart.
  - Assert reset during WAIT of a store of 0xCAFEF00D to 0x20 → no rsp_valid pulse, and a later load from 0x20 returns the old data.

Source files
------------

// File: rtl/dmem_responder.sv
//==============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with fixed-latency ready/valid handshake,
//            word/byte access on a little-endian word RAM, and fault reporting.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int          c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          c_cw    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [29:0] c_depth = 30'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_cw-1:0]   r_cnt;
   logic              r_we;
   logic              r_byte;
   logic              r_fault;
   logic [c_iw-1:0]   r_idx;
   logic [1:0]        r_lane;
   logic [31:0]       r_wdata;
   logic              r_ready;
   logic              r_valid;
   logic [31:0]       r_rdata;
   logic              r_rsp_fault;
   logic [31:0]       r_mem [DEPTH];

   logic              w_fault;
   logic              w_access;

   // Range is checked on the full word index so high address bits never alias.
   assign w_fault  = (~req_byte & (|req_addr[1:0])) | (req_addr[31:2] >= c_depth);
   assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_byte      <= 1'b0;
         r_fault     <= 1'b0;
         r_idx       <= '0;
         r_lane      <= 2'd0;
         r_wdata     <= 32'd0;
         r_ready     <= 1'b1;
         r_valid     <= 1'b0;
         r_rdata     <= 32'd0;
         r_rsp_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_byte  <= req_byte;
                  r_fault <= w_fault;
                  r_idx   <= req_addr[c_iw+1:2];
                  r_lane  <= req_addr[1:0];
                  r_wdata <= req_wdata;
                  r_cnt   <= c_cw'(LATENCY - 1);
                  r_ready <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_cw'(1);
               end else begin
                  r_state     <= S_RESP;
                  r_valid     <= 1'b1;
                  r_rsp_fault <= r_fault;
                  if (r_we || r_fault)
                     r_rdata <= 32'd0;
                  else if (r_byte)
                     r_rdata <= {24'd0, r_mem[r_idx][{r_lane, 3'b000} +: 8]};
                  else
                     r_rdata <= r_mem[r_idx];
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_valid     <= 1'b0;
               r_rsp_fault <= 1'b0;
               r_ready     <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_valid     <= 1'b0;
               r_rsp_fault <= 1'b0;
               r_ready     <= 1'b1;
            end
         endcase
      end
   end

   // RAM is not reset; the reset term in the enable blocks a write when reset is held low.
   always_ff @(posedge clk) begin
      if (reset && w_access && r_we && !r_fault) begin
         if (r_byte)
            r_mem[r_idx][{r_lane, 3'b000} +: 8] <= r_wdata[7:0];
         else
            r_mem[r_idx] <= r_wdata;
      end
   end

   assign req_ready = r_ready;
   assign rsp_valid = r_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_fault = r_rsp_fault;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder (DEPTH=64, LATENCY=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

   localparam int c_lat = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   typedef struct {
      logic        we;
      logic        byt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
   } exp_t;

   exp_t sb[$];
   vec_t vt[20];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   dmem_responder #(.DEPTH(64), .LATENCY(c_lat)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_fault (rsp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Scoreboard: every response pulse pops one expectation.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
            chk("rsp_latency", cyc - e.acc, c_lat);
            chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic xact(input vec_t v);
      int n = 0;
      wait_ready();
      req_valid = 1'b1;
      req_we    = v.we;
      req_byte  = v.byt;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      sb.push_back('{rdata: v.rdata, fault: v.fault, acc: cyc});
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_fault"}, {31'd0, rsp_fault}, 32'd0);
   endtask

   initial begin
      int last_acc;
      vt[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 32'h0000_0013, 32'hFFFF_FFA5, 32'h0000_0000, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hA5AD_BEEF, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_00AD, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_0000, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1111_2222, 32'h0000_0000, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h5566_7788, 32'h0000_0000, 1'b0};
      vt[10] = '{1'b0, 1'b1, 32'h0000_0023, 32'h0,         32'h0000_0055, 1'b0};
      vt[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0088, 1'b0};
      vt[12] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0A0B_0C0D, 32'h0000_0000, 1'b0};
      vt[13] = '{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         32'h0A0B_0C0D, 1'b0};
      vt[14] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1};
      vt[15] = '{1'b1, 1'b0, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vt[16] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hA5AD_BEEF, 1'b0};
      vt[17] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         32'h0000_0000, 1'b1};
      vt[18] = '{1'b1, 1'b1, 32'h8000_0000, 32'h0000_0099, 32'h0000_0000, 1'b1};
      vt[19] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0};

      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("in_reset");
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      for (int i = 0; i < 20; i++) xact(vt[i]);

      // Back-to-back accepts with req_valid held high.
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 32'h10;
      last_acc  = 0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) wait_ready();
         @(posedge clk);
         #1;
         sb.push_back('{rdata: 32'hA5AD_BEEF, fault: 1'b0, acc: cyc});
         chk("ready_in_wait", {31'd0, req_ready}, 32'd0);
         if (k > 0) chk("accept_spacing", cyc - last_acc, c_lat + 2);
         last_acc = cyc;
      end
      req_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("stall_sb_drained", sb.size(), 32'd0);
      sb.delete();

      // Abort a store mid-WAIT with reset; memory must keep the old word.
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_byte  = 1'b0;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_idle_outputs("abort_reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk_idle_outputs("abort_after");
      xact('{1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h5566_7788, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
